cpu_prog_mem: RTL and testbench
===============================

CPU_PROG_MEM -- requirements
Module: cpu_prog_mem

Interface
REQ-001 Parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, meaning instruction word width.
REQ-003 clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  meaning synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 addr  input  ADDR_W  meaning fetch address from the CPU program counter.
REQ-006 data  output  DATA_W  meaning combinational fetch word.
REQ-007 data_d  output  DATA_W  meaning fetch word registered one cycle.
REQ-008 ld_start  input  1  meaning a one-cycle request to enter program-load mode.
REQ-009 ld_valid  input  1  meaning a load word is present on ld_data.
REQ-010 ld_data  input  DATA_W  meaning the load word.
REQ-011 ld_last  input  1  meaning the current load word is the final word.
REQ-012 ld_ready  output  1  meaning the block accepts a load word this cycle.
REQ-013 cpu_hold  output  1  meaning the CPU shall stall; high while in LOAD.
REQ-014 ld_done  output  1  meaning a one-cycle pulse when a load completes.
REQ-015 ld_cnt  output  ADDR_W+1  meaning the number of words written by the last load.

Function
REQ-016 Storage SHALL be a DEPTH x DATA_W flop array, writable only through the load port.
REQ-017 FSM SHALL have two states: RUN and LOAD.
REQ-018 RUN -> LOAD SHALL occur on the edge at which ld_start=1; the write pointer is set to 0 and ld_cnt is cleared to 0.
REQ-019 In LOAD, ld_ready SHALL be 1 (combinational from state); in RUN, ld_ready SHALL be 0.
REQ-020 In RUN, ld_valid, ld_data and ld_last SHALL be ignored, with no write.
REQ-021 In LOAD, ld_start SHALL be ignored; a load already in progress is not restarted.
REQ-022 Accept (ld_valid & ld_ready) SHALL write ld_data to mem[ptr], increment ptr, and increment ld_cnt, all on the same edge.
REQ-023 LOAD -> RUN SHALL occur on an accept with ld_last=1, or on an accept at ptr=DEPTH-1, whichever comes first; ld_done SHALL be 1 for exactly the following cycle.
REQ-024 ptr SHALL never wrap: after the word at DEPTH-1 is accepted, the state is RUN. ld_cnt max SHALL be DEPTH.
REQ-025 Words not written during a load SHALL retain their previous contents.
REQ-026 cpu_hold SHALL equal (state==LOAD).
REQ-027 data SHALL be mem[addr] in RUN and 0 in LOAD.
REQ-028 data_d SHALL register data every cycle, so data_d(t+1) = data(t); data_d therefore shows 0 the cycle after any LOAD cycle.
REQ-029 A write and a fetch of the same address cannot coincide, because data is forced to 0 in LOAD; no bypass is required.

Reset
REQ-030 On rst=1, state SHALL be RUN, ptr=0, ld_cnt=0, ld_done=0, and data_d=0.
REQ-031 On rst=1, mem SHALL reload the default image: B7 01 E1 01 E3 B6 01 E6 01 E8 B0 B4 01 EA B8 FF (hex, address 0..15).
REQ-032 For DEPTH>16, words 16..DEPTH-1 SHALL reset to 0; for DEPTH<16, the image SHALL be truncated.
REQ-033 Image words SHALL be zero-extended when DATA_W>8 and truncated to the low DATA_W bits when DATA_W<8.
REQ-034 rst asserted mid-load SHALL abort the load: state RUN, default image restored, and no ld_done pulse.
REQ-035 rst SHALL have priority over ld_start and over an accept on the same edge.

Verification
REQ-036 Reset, then sweep addr 0..15 in RUN -> data matches the default image; data_d lags data by 1 cycle; addr=15 -> FF.
REQ-037 ld_start, then 4 words AA,55,0F,F0 with ld_last on the 4th -> mem[0..3] updated, mem[4..15] unchanged, ld_done pulses once, ld_cnt=4, cpu_hold high for exactly 5 cycles.
REQ-038 Load 16 words without ld_last -> return to RUN after the 16th accept; ld_cnt=16; extra ld_valid in RUN writes nothing.
REQ-039 ld_valid toggled with gaps during load, and ld_start pulsed mid-load -> only accepted words are written; pointer not restarted; data=0 and data_d=0 during LOAD.
REQ-040 rst asserted after 2 load words -> default image restored (mem[0]=B7, mem[1]=01), state RUN, no ld_done pulse.
REQ-041 ADDR_W=5, DATA_W=12 build with reset -> mem[0]=0B7, mem[16..31]=000; a 32-word load yields ld_cnt=32.

Source files
------------

// File: rtl/cpu_prog_mem.sv
// cpu_prog_mem: flop-array program memory for a small CPU.
// A streaming load port rewrites it and stalls the CPU while loading.
module cpu_prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] data_d,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Boot image; words past 15 are zero, width adapts to DATA_W.
    function automatic logic [DATA_W-1:0] boot_word(input int idx);
        logic [7:0] b;
        case (idx)
            0:       b = 8'hB7;
            1:       b = 8'h01;
            2:       b = 8'hE1;
            3:       b = 8'h01;
            4:       b = 8'hE3;
            5:       b = 8'hB6;
            6:       b = 8'h01;
            7:       b = 8'hE6;
            8:       b = 8'h01;
            9:       b = 8'hE8;
            10:      b = 8'hB0;
            11:      b = 8'hB4;
            12:      b = 8'h01;
            13:      b = 8'hEA;
            14:      b = 8'hB8;
            15:      b = 8'hFF;
            default: b = 8'h00;
        endcase
        return DATA_W'(b);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     cnt_q;
    logic                done_q;
    logic [DATA_W-1:0]   dd_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                accept;
    logic                last_word;
    logic [DATA_W-1:0]   fetch;

    // Next state and accept decode; the last slot ends a load.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_word = 1'b0;
        case (state_q)
            RUN: begin
                if (ld_start) state_d = LOAD;
            end
            LOAD: begin
                accept    = ld_valid;
                last_word = ld_last || (ptr_q == ADDR_W'(DEPTH - 1));
                if (accept && last_word) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Write pointer, word count and the completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= accept && last_word;
            if (state_q == RUN && ld_start) begin
                ptr_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                if (!last_word) ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Storage: boot image on reset, otherwise written only by accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= boot_word(i);
        end else if (accept) begin
            mem_q[ptr_q] <= ld_data;
        end
    end

    // Fetch is blanked while loading, so no write/read bypass is needed.
    assign fetch = (state_q == RUN) ? mem_q[addr] : '0;

    // One-cycle delayed copy of the fetch word.
    always_ff @(posedge clk) begin
        if (rst) dd_q <= '0;
        else     dd_q <= fetch;
    end

    assign data     = fetch;
    assign data_d   = dd_q;
    assign ld_ready = (state_q == LOAD);
    assign cpu_hold = (state_q == LOAD);
    assign ld_done  = done_q;
    assign ld_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_prog_mem.sv
// tb_cpu_prog_mem: scoreboard bench for cpu_prog_mem,
// default build plus a wide 5/12 build on the same clock.
module tb_cpu_prog_mem;

    logic       clk;
    logic       rst;
    logic [3:0] addr;
    logic [7:0] data, data_d, ld_data;
    logic       ld_start, ld_valid, ld_last;
    logic       ld_ready, cpu_hold, ld_done;
    logic [4:0] ld_cnt;

    logic [4:0]  b_addr;
    logic [11:0] b_data, b_data_d, b_ld_data;
    logic        b_start, b_valid, b_last;
    logic        b_ready, b_hold, b_done;
    logic [5:0]  b_cnt;

    int nvec = 0;
    int miscmp = 0;
    int holdcnt = 0;
    int donecnt = 0;
    logic [7:0] sbq [$];

    logic [7:0] img [16] = '{8'hB7, 8'h01, 8'hE1, 8'h01,
                             8'hE3, 8'hB6, 8'h01, 8'hE6,
                             8'h01, 8'hE8, 8'hB0, 8'hB4,
                             8'h01, 8'hEA, 8'hB8, 8'hFF};
    logic [7:0] mdl [16];
    logic [7:0] words [4] = '{8'hAA, 8'h55, 8'h0F, 8'hF0};

    cpu_prog_mem dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data     (data),
        .data_d   (data_d),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .ld_cnt   (ld_cnt)
    );

    cpu_prog_mem #(.ADDR_W(5), .DATA_W(12)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .addr     (b_addr),
        .data     (b_data),
        .data_d   (b_data_d),
        .ld_start (b_start),
        .ld_valid (b_valid),
        .ld_data  (b_ld_data),
        .ld_last  (b_last),
        .ld_ready (b_ready),
        .cpu_hold (b_hold),
        .ld_done  (b_done),
        .ld_cnt   (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One cycle: check comb outputs, queue expected fetch, then
    // check the registered copy after the edge.
    task automatic step(input logic [7:0] ed, input logic eh);
        #1;
        chk("data", 32'(data), 32'(ed));
        chk("hold", 32'(cpu_hold), 32'(eh));
        chk("ready", 32'(ld_ready), 32'(eh));
        if (cpu_hold) holdcnt++;
        sbq.push_back(ed);
        @(posedge clk);
        #1;
        chk("data_d", 32'(data_d), 32'(sbq.pop_front()));
        if (ld_done) donecnt++;
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            step(mdl[a], 1'b0);
        end
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step(mdl[addr], 1'b0);
        ld_start = 1'b0;
    endtask

    initial begin
        int d0;
        rst = 1'b1; addr = '0; ld_start = 0; ld_valid = 0;
        ld_data = '0; ld_last = 0;
        b_addr = '0; b_start = 0; b_valid = 0; b_ld_data = '0; b_last = 0;
        for (int i = 0; i < 16; i++) mdl[i] = img[i];

        // reset state
        @(posedge clk); #1;
        chk("rst_data_d", 32'(data_d), 32'h0);
        chk("rst_cnt", 32'(ld_cnt), 32'h0);
        chk("rst_done", 32'(ld_done), 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_ready", 32'(ld_ready), 32'h0);
        rst = 1'b0;

        // default image sweep, addr 15 is FF
        sweep();
        addr = 4'd15;
        #1 chk("addr15", 32'(data), 32'hFF);

        // 4-word load with ld_last, one idle LOAD cycle first
        addr = 4'd2;
        holdcnt = 0; d0 = donecnt;
        start_load();
        step(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
            step(8'h00, 1'b1);
            mdl[i] = words[i];
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("done4_pulse", 32'(ld_done), 32'h1);
        chk("cnt4", 32'(ld_cnt), 32'd4);
        step(mdl[addr], 1'b0);
        chk("done4_clear", 32'(ld_done), 32'h0);
        chk("hold5", 32'(holdcnt), 32'd5);
        sweep();
        chk("done4_once", 32'(donecnt - d0), 32'd1);

        // 16 words without ld_last, then ld_valid in RUN
        d0 = donecnt;
        start_load();
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1; ld_data = 8'(8'h10 + i); ld_last = 1'b0;
            step(8'h00, 1'b1);
            mdl[i] = 8'(8'h10 + i);
        end
        chk("full_run", 32'(cpu_hold), 32'h0);
        chk("cnt16", 32'(ld_cnt), 32'd16);
        ld_data = 8'h99;
        step(mdl[addr], 1'b0);
        step(mdl[addr], 1'b0);
        ld_valid = 1'b0;
        sweep();
        chk("done16_once", 32'(donecnt - d0), 32'd1);
        chk("cnt16_hold", 32'(ld_cnt), 32'd16);

        // gaps, stray ld_last, ld_start mid-load
        start_load();
        ld_valid = 1; ld_data = 8'hC1; ld_last = 0; step(8'h00, 1'b1);
        ld_valid = 0; ld_data = 8'hEE; ld_last = 1; step(8'h00, 1'b1);
        ld_valid = 1; ld_data = 8'hC2; ld_last = 0; ld_start = 1;
        step(8'h00, 1'b1);
        ld_start = 0;
        ld_valid = 0; ld_data = 8'hDD; ld_last = 0; step(8'h00, 1'b1);
        ld_valid = 1; ld_data = 8'hC3; ld_last = 1; step(8'h00, 1'b1);
        ld_valid = 0; ld_last = 0;
        mdl[0] = 8'hC1; mdl[1] = 8'hC2; mdl[2] = 8'hC3;
        chk("cnt3", 32'(ld_cnt), 32'd3);
        sweep();

        // reset after 2 words aborts the load
        d0 = donecnt;
        start_load();
        ld_valid = 1; ld_data = 8'h31; step(8'h00, 1'b1);
        ld_data = 8'h32; step(8'h00, 1'b1);
        rst = 1; ld_data = 8'h77; ld_start = 1;
        @(posedge clk); #1;
        chk("abort_hold", 32'(cpu_hold), 32'h0);
        chk("abort_done", 32'(ld_done), 32'h0);
        chk("abort_cnt", 32'(ld_cnt), 32'h0);
        chk("abort_dd", 32'(data_d), 32'h0);
        rst = 0; ld_valid = 0; ld_start = 0;
        @(posedge clk); #1;
        chk("abort_nodone", 32'(ld_done), 32'h0);
        chk("abort_nodone_cnt", 32'(donecnt - d0), 32'd0);
        sbq.delete();
        for (int i = 0; i < 16; i++) mdl[i] = img[i];
        sweep();

        // wide build: extended image, zero tail, 32-word load
        b_addr = 5'd0;
        #1 chk("w_addr0", 32'(b_data), 32'h0B7);
        b_addr = 5'd15;
        #1 chk("w_addr15", 32'(b_data), 32'h0FF);
        for (int a = 16; a < 32; a++) begin
            b_addr = 5'(a);
            #1 chk("w_tail", 32'(b_data), 32'h000);
        end
        @(posedge clk); #1;
        b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        chk("w_hold", 32'(b_hold), 32'h1);
        for (int i = 0; i < 32; i++) begin
            b_valid = 1; b_ld_data = 12'(12'h100 + i);
            @(posedge clk); #1;
        end
        b_valid = 0;
        chk("w_cnt32", 32'(b_cnt), 32'd32);
        chk("w_done", 32'(b_done), 32'h1);
        chk("w_run", 32'(b_hold), 32'h0);
        b_addr = 5'd0;
        #1 chk("w_new0", 32'(b_data), 32'h100);
        b_addr = 5'd31;
        #1 chk("w_new31", 32'(b_data), 32'h11F);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, miscmp);
        $finish;
    end

endmodule
